// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: computes result/zero/branch per op behind a
// valid/ready handshake with a 2-entry skid buffer and a delivered-op counter.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             br_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             br_taken;
    logic             illegal;
  } rec_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  rec_t             r_main;
  rec_t             r_skid;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_deliver;
  logic             w_load_main_new;
  logic             w_load_main_skid;
  logic             w_load_skid;
  rec_t             w_new;
  logic [WIDTH-1:0] w_diff;
  logic             w_eq;
  logic             w_lt_s;
  logic             w_lt_u;

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_out_valid && out_ready;

  assign w_diff = op_a - op_b;
  assign w_eq   = (op_a == op_b);
  assign w_lt_s = ($signed(op_a) < $signed(op_b));
  assign w_lt_u = (op_a < op_b);

  always_comb begin
    w_new.result   = '0;
    w_new.br_taken = 1'b0;
    w_new.illegal  = 1'b0;
    unique case (alu_ctrl)
      4'd0:  w_new.result = op_a & op_b;
      4'd1:  w_new.result = op_a | op_b;
      4'd2:  w_new.result = op_a + op_b;
      4'd3:  w_new.result = w_diff;
      4'd4:  w_new.result = op_a ^ op_b;
      4'd5:  begin w_new.result = w_diff; w_new.br_taken = w_eq;    end
      4'd6:  begin w_new.result = w_diff; w_new.br_taken = !w_eq;   end
      4'd7:  begin w_new.result = w_diff; w_new.br_taken = w_lt_s;  end
      4'd8:  begin w_new.result = w_diff; w_new.br_taken = !w_lt_s; end
      4'd9:  begin w_new.result = w_diff; w_new.br_taken = w_lt_u;  end
      4'd10: begin w_new.result = w_diff; w_new.br_taken = !w_lt_u; end
      default: w_new.illegal = 1'b1;
    endcase
    // zero always follows the stored result, so illegal codes get zero=1
    w_new.zero = (w_new.result == '0);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = S_ONE;
          w_load_main_new = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_deliver) begin
          w_load_main_new = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_deliver) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_load_main_new) begin
        r_main <= w_new;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_new;
      end
      if (w_deliver) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_main.result;
  assign zero      = r_main.zero;
  assign br_taken  = r_main.br_taken;
  assign illegal   = r_main.illegal;
  assign op_count  = r_op_count;

endmodule
